// File: rtl/axi_ic_pkg.sv
// ============================================================================
// Module  : axi_ic_pkg
// Brief   : Shared types, constants and helpers for the AXI write arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package axi_ic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } st_e;

   localparam int QOS_W = 4;

   // Sized for the largest supported master count (16).
   function automatic logic [3:0] onehot2bin(input logic [15:0] i_oh);
      logic [3:0] w_bin;
      w_bin = '0;
      for (int i = 0; i < 16; i++) begin
         if (i_oh[i]) w_bin = w_bin | 4'(i);
      end
      return w_bin;
   endfunction

endpackage

`default_nettype wire

// File: rtl/axi_wr_arbiter_if.sv
// ============================================================================
// Module  : axi_wr_arbiter_if
// Brief   : AW/W handshake bundle between upstream masters, arbiter, downstream.
//           AXI_ARB_QOS_EN adds the per-master AWQOS vector.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface axi_wr_arbiter_if
   import axi_ic_pkg::*;
#(
   parameter int NM = 4
);
   logic [NM-1:0] i_awvalid;
   logic [NM-1:0] o_awready;
   logic [NM-1:0] i_wvalid;
   logic [NM-1:0] i_wlast;
   logic [NM-1:0] o_wready;
   logic          o_awvalid;
   logic          i_awready;
   logic          o_wvalid;
   logic          o_wlast;
   logic          i_wready;
`ifdef AXI_ARB_QOS_EN
   logic [QOS_W*NM-1:0] i_awqos;
`endif

   modport slave (
      input  i_awvalid, i_wvalid, i_wlast, i_awready, i_wready,
      output o_awready, o_wready, o_awvalid, o_wvalid, o_wlast
`ifdef AXI_ARB_QOS_EN
      , input i_awqos
`endif
   );

   modport master (
      output i_awvalid, i_wvalid, i_wlast, i_awready, i_wready,
      input  o_awready, o_wready, o_awvalid, o_wvalid, o_wlast
`ifdef AXI_ARB_QOS_EN
      , output i_awqos
`endif
   );
endinterface

`default_nettype wire

// File: rtl/axi_rr_arbiter.sv
// ============================================================================
// Module  : axi_rr_arbiter
// Brief   : Combinational round-robin pick from i_ptr; with AXI_ARB_QOS_EN the
//           highest QOS wins and round-robin order breaks ties.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_rr_arbiter
   import axi_ic_pkg::*;
#(
   parameter int NM = 4,
   parameter int MW = $clog2(NM)
) (
   input  logic [NM-1:0]       i_req,
   input  logic [MW-1:0]       i_ptr,
`ifdef AXI_ARB_QOS_EN
   input  logic [QOS_W*NM-1:0] i_qos,
`endif
   output logic [NM-1:0]       o_grant,
   output logic [MW-1:0]       o_grant_id
);

   always_comb begin
      logic             w_found;
      logic [QOS_W-1:0] w_best;
      logic [QOS_W-1:0] w_q;
      logic             w_r;
      int               w_idx;
      int               w_sel;
      w_found = 1'b0;
      w_best  = '0;
      w_sel   = 0;
      o_grant = '0;
      // Walk requesters in rotated order; strict '>' keeps the earliest on ties.
      for (int k = 0; k < NM; k++) begin
         w_idx = int'(i_ptr) + k;
         if (w_idx >= NM) w_idx = w_idx - NM;
         w_r = 1'b0;
         w_q = '0;
         for (int j = 0; j < NM; j++) begin
            if (j == w_idx) begin
               w_r = i_req[j];
`ifdef AXI_ARB_QOS_EN
               w_q = i_qos[j*QOS_W +: QOS_W];
`endif
            end
         end
         if (w_r && (!w_found || (w_q > w_best))) begin
            w_found = 1'b1;
            w_best  = w_q;
            w_sel   = w_idx;
         end
      end
      for (int j = 0; j < NM; j++) begin
         o_grant[j] = w_found && (w_sel == j);
      end
      o_grant_id = MW'(onehot2bin(16'(o_grant)));
   end

endmodule

`default_nettype wire

// File: rtl/axi_wr_arbiter.sv
// ============================================================================
// Module  : axi_wr_arbiter
// Brief   : Shares one AXI AW+W channel among NM masters; grant held to WLAST.
//           AXI_ARB_QOS_EN enables QOS-priority arbitration.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_wr_arbiter
   import axi_ic_pkg::*;
#(
   parameter int NM  = 4,
   parameter int MW  = $clog2(NM),
   parameter int BCW = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   axi_wr_arbiter_if.slave  bus,
   output logic [NM-1:0]    o_grant,
   output logic [MW-1:0]    o_grant_id,
   output logic             o_busy,
   output logic [BCW-1:0]   o_beat_cnt
);

   st_e            r_state;
   logic [NM-1:0]  r_grant;
   logic [MW-1:0]  r_grant_id;
   logic [MW-1:0]  r_rr_ptr;
   logic [BCW-1:0] r_beat_cnt;

   logic [NM-1:0]  w_arb_grant;
   logic [MW-1:0]  w_arb_id;
   logic           w_in_addr;
   logic           w_in_data;
   logic           w_aw_hs;
   logic           w_w_hs;
   logic [MW-1:0]  w_ptr_nxt;

   axi_rr_arbiter #(.NM(NM), .MW(MW)) u_arb (
      .i_req      (bus.i_awvalid),
      .i_ptr      (r_rr_ptr),
`ifdef AXI_ARB_QOS_EN
      .i_qos      (bus.i_awqos),
`endif
      .o_grant    (w_arb_grant),
      .o_grant_id (w_arb_id)
   );

   assign w_in_addr = (r_state == ST_ADDR);
   assign w_in_data = (r_state == ST_DATA);

   // Steering is masked by the registered one-hot grant, so no payload index is needed.
   assign bus.o_awvalid = w_in_addr & |(bus.i_awvalid & r_grant);
   assign bus.o_awready = w_in_addr ? (r_grant & {NM{bus.i_awready}}) : '0;
   assign bus.o_wvalid  = w_in_data & |(bus.i_wvalid & r_grant);
   assign bus.o_wlast   = w_in_data & |(bus.i_wlast & r_grant);
   assign bus.o_wready  = w_in_data ? (r_grant & {NM{bus.i_wready}}) : '0;

   assign w_aw_hs   = bus.o_awvalid & bus.i_awready;
   assign w_w_hs    = bus.o_wvalid & bus.i_wready;
   assign w_ptr_nxt = (r_grant_id == MW'(NM-1)) ? '0 : r_grant_id + MW'(1);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_grant    <= '0;
         r_grant_id <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_beat_cnt <= '0;
               if (|bus.i_awvalid) begin
                  r_grant    <= w_arb_grant;
                  r_grant_id <= w_arb_id;
                  r_state    <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (w_aw_hs) r_state <= ST_DATA;
            end
            ST_DATA: begin
               if (w_w_hs) begin
                  if (bus.o_wlast) begin
                     r_state    <= ST_IDLE;
                     r_grant    <= '0;
                     r_grant_id <= '0;
                     r_rr_ptr   <= w_ptr_nxt;
                     r_beat_cnt <= '0;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + BCW'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_grant    = r_grant;
   assign o_grant_id = r_grant_id;
   assign o_busy     = (r_state != ST_IDLE);
   assign o_beat_cnt = r_beat_cnt;

endmodule

`default_nettype wire

// File: tb/tb_axi_wr_arbiter.sv
// ============================================================================
// Module  : tb_axi_wr_arbiter
// Brief   : Scoreboard bench for axi_wr_arbiter; QOS cases need AXI_ARB_QOS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_wr_arbiter;
   import axi_ic_pkg::*;

   localparam int NM  = 4;
   localparam int MW  = 2;
   localparam int BCW = 8;

   typedef struct {
      int id;
      int len;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NM-1:0]  grant;
   logic [MW-1:0]  gid;
   logic           busy;
   logic [BCW-1:0] bcnt;

   int   errors = 0;
   int   checks = 0;
   exp_t expq[$];

   int   nreq[NM];
   int   blen[NM];
   int   beat[NM];
   bit   wact[NM];
   bit   wtoggle = 1'b0;

   bit   mon_act = 1'b0;
   int   mon_cnt = 0;
   int   cur_len = 0;
   int   cur_id  = 0;

   always #5 clk = ~clk;

   axi_wr_arbiter_if #(.NM(NM)) bus ();

   axi_wr_arbiter #(.NM(NM), .MW(MW), .BCW(BCW)) dut (
      .i_clk      (clk),
      .i_reset    (rst),
      .bus        (bus),
      .o_grant    (grant),
      .o_grant_id (gid),
      .o_busy     (busy),
      .o_beat_cnt (bcnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      for (int m = 0; m < NM; m++) begin
         bus.i_awvalid[m] = (nreq[m] > 0) && !wact[m];
         bus.i_wvalid[m]  = wact[m];
         bus.i_wlast[m]   = wact[m] && (beat[m] == blen[m] - 1);
      end
   endtask

   task automatic clear_masters();
      for (int m = 0; m < NM; m++) begin
         nreq[m] = 0;
         blen[m] = 1;
         beat[m] = 0;
         wact[m] = 1'b0;
      end
      drive();
   endtask

   task automatic start(input int m, input int len, input int n);
      nreq[m] = n;
      blen[m] = len;
      drive();
   endtask

   // Masters react to handshakes seen at the edge, then update 1 time unit later.
   task automatic cycle();
      bit aw_hs[NM];
      bit w_hs[NM];
      @(posedge clk);
      for (int m = 0; m < NM; m++) begin
         aw_hs[m] = bus.i_awvalid[m] & bus.o_awready[m];
         w_hs[m]  = bus.i_wvalid[m] & bus.o_wready[m];
      end
      #1;
      for (int m = 0; m < NM; m++) begin
         if (aw_hs[m]) begin
            nreq[m]--;
            wact[m] = 1'b1;
            beat[m] = 0;
         end
         if (w_hs[m]) begin
            beat[m]++;
            if (beat[m] == blen[m]) wact[m] = 1'b0;
         end
      end
      if (wtoggle) bus.i_wready = ~bus.i_wready;
      drive();
   endtask

   task automatic wait_idle(input int maxc);
      bit done;
      done = 1'b0;
      for (int i = 0; i < maxc && !done; i++) begin
         cycle();
         done = !busy;
         for (int m = 0; m < NM; m++) begin
            if (nreq[m] != 0 || wact[m]) done = 1'b0;
         end
      end
      if (!done) chk("idle_timeout", 1, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_masters();
   endtask

   // Monitor: pops expected owner at each downstream AW handshake, tracks beats.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         mon_act = 1'b0;
      end else begin
         if (bus.o_awvalid && bus.i_awready) begin
            if (expq.size() == 0) begin
               chk("aw_unexpected", 1, 0);
            end else begin
               e = expq.pop_front();
               chk("aw_grant_id", 64'(gid), 64'(e.id));
               cur_id  = e.id;
               cur_len = e.len;
               mon_cnt = 0;
               mon_act = 1'b1;
            end
         end
         if (bus.o_wvalid && bus.i_wready) begin
            chk("w_owner", 64'(gid), 64'(cur_id));
            chk("beat_cnt", 64'(bcnt), 64'(mon_cnt % 256));
            mon_cnt++;
            if (bus.o_wlast) begin
               chk("burst_len", 64'(mon_cnt), 64'(cur_len));
               mon_act = 1'b0;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.i_awready = 1'b1;
      bus.i_wready  = 1'b1;
`ifdef AXI_ARB_QOS_EN
      bus.i_awqos   = '0;
`endif
      clear_masters();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      chk("rst_busy", 64'(busy), 0);
      chk("rst_grant", 64'(grant), 0);
      chk("rst_gid", 64'(gid), 0);
      chk("rst_beat", 64'(bcnt), 0);
      chk("rst_awready", 64'(bus.o_awready), 0);
      chk("rst_wready", 64'(bus.o_wready), 0);
      chk("rst_ptr", 64'(dut.r_rr_ptr), 0);

      // Single M1 burst, 4 beats: one cycle to grant
      expq.push_back('{1, 4});
      start(1, 4, 1);
      cycle();
      chk("single_gid", 64'(gid), 1);
      chk("single_grant", 64'(grant), 64'h2);
      chk("single_awvalid", 64'(bus.o_awvalid), 1);
      wait_idle(50);
      chk("single_ptr", 64'(dut.r_rr_ptr), 2);
      chk("single_beat_idle", 64'(bcnt), 0);

      // Fairness from rr_ptr=0: order 0,1,2,3,0
      do_reset();
      expq.push_back('{0, 1});
      expq.push_back('{1, 1});
      expq.push_back('{2, 1});
      expq.push_back('{3, 1});
      expq.push_back('{0, 1});
      start(0, 1, 2);
      start(1, 1, 1);
      start(2, 1, 1);
      start(3, 1, 1);
      wait_idle(100);
      chk("fair_ptr", 64'(dut.r_rr_ptr), 1);

      // Backpressure: AW stalled 5 cycles, W ready toggling
      bus.i_awready = 1'b0;
      expq.push_back('{2, 3});
      start(2, 3, 1);
      cycle();
      for (int i = 0; i < 5; i++) begin
         chk("bp_gid", 64'(gid), 2);
         chk("bp_awready", 64'(bus.o_awready), 0);
         chk("bp_awvalid", 64'(bus.o_awvalid), 1);
         cycle();
      end
      bus.i_awready = 1'b1;
      #0;
      chk("bp_awready_track", 64'(bus.o_awready), 64'h4);
      wtoggle = 1'b1;
      wait_idle(50);
      wtoggle = 1'b0;
      bus.i_wready = 1'b1;
      chk("bp_ptr", 64'(dut.r_rr_ptr), 3);

      // Wrap: rr_ptr=3, M0 and M2 request -> M0 first; 256-beat burst
      expq.push_back('{0, 256});
      expq.push_back('{2, 2});
      start(0, 256, 1);
      start(2, 2, 1);
      wait_idle(700);
      chk("wrap_ptr", 64'(dut.r_rr_ptr), 3);
      chk("wrap_beat_idle", 64'(bcnt), 0);

      // Reset in DATA after 2 of 8 beats
      expq.push_back('{1, 8});
      start(1, 8, 1);
      for (int i = 0; i < 30 && bcnt != 8'd2; i++) cycle();
      chk("mid_reached", 64'(bcnt), 2);
      do_reset();
      chk("mid_busy", 64'(busy), 0);
      chk("mid_grant", 64'(grant), 0);
      chk("mid_ptr", 64'(dut.r_rr_ptr), 0);
      chk("mid_beat", 64'(bcnt), 0);
      chk("mid_wready", 64'(bus.o_wready), 0);

`ifdef AXI_ARB_QOS_EN
      // M0 qos=2, M3 qos=9 from rr_ptr=0 -> M3 then M0
      bus.i_awqos = {4'd9, 4'd0, 4'd0, 4'd2};
      expq.push_back('{3, 1});
      expq.push_back('{0, 1});
      start(0, 1, 1);
      start(3, 1, 1);
      wait_idle(50);
      // Equal qos after reset: plain round-robin 1 then 2
      do_reset();
      bus.i_awqos = {4'd5, 4'd5, 4'd5, 4'd5};
      expq.push_back('{1, 1});
      expq.push_back('{2, 1});
      start(1, 1, 1);
      start(2, 1, 1);
      wait_idle(50);
`endif

      chk("queue_empty", 64'(expq.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
